// File: rtl/nabp_line_loader_pkg.sv
// nabp_line_loader_pkg: shared sizes, bank index type and write-FSM encoding for the line loader.
// Optional feature macro: NABP_LINE_LOADER_ZERO_PAD_EN adds the PAD state.
package nabp_line_loader_pkg;
   localparam int kFilteredDataLength = 16;
   localparam int kProjectionLineSize = 256;
   localparam int kSLength            = 8;
   localparam int kBankW              = 1;
   typedef logic [kBankW-1:0] bank_t;
`ifdef NABP_LINE_LOADER_ZERO_PAD_EN
   typedef enum logic [1:0] {ST_FILL, ST_WAIT, ST_PAD} state_t;
`else
   typedef enum logic [1:0] {ST_FILL, ST_WAIT} state_t;
`endif
endpackage

// File: rtl/nabp_line_loader_if.sv
// nabp_line_loader_if: sample stream, RAM write port and line status bundle.
// slave  (loader): in_valid/in_data/in_last/line_release in; in_ready, wr_*, line_valid/line_bank out.
// master (environment): the mirror image.
interface nabp_line_loader_if
   import nabp_line_loader_pkg::*;
#(
   parameter int pDataLength = kFilteredDataLength,
   parameter int pAddrLength = kSLength
);
   logic                   in_valid, in_last, in_ready;
   logic [pDataLength-1:0] in_data;
   logic                   wr_we_0, wr_we_1;
   logic [pAddrLength-1:0] wr_addr;
   logic [pDataLength-1:0] wr_data;
   logic                   line_valid, line_release;
   bank_t                  line_bank;
   modport slave (
      input  in_valid, in_data, in_last, line_release,
      output in_ready, wr_we_0, wr_we_1, wr_addr, wr_data, line_valid, line_bank
   );
   modport master (
      output in_valid, in_data, in_last, line_release,
      input  in_ready, wr_we_0, wr_we_1, wr_addr, wr_data, line_valid, line_bank
   );
endinterface

// File: rtl/nabp_bank_tracker.sv
// nabp_bank_tracker: per-bank empty/pending/full flags and the read-bank pointer.
// Ports: clk, reset_n; i_mark/i_mark_bank (line written), i_release (reader done);
//        o_empty/o_empty_nxt (current/next emptiness), o_line_valid/o_line_bank (registered).
module nabp_bank_tracker
   import nabp_line_loader_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_mark,
   input  bank_t      i_mark_bank,
   input  logic       i_release,
   output logic [1:0] o_empty,
   output logic [1:0] o_empty_nxt,
   output logic       o_line_valid,
   output bank_t      o_line_bank
);
   logic [1:0] r_pend, r_full, w_pend_nxt, w_full_nxt;
   logic       r_line_valid, w_rel;
   bank_t      r_rb, w_rb_nxt;
   // Pending delays "full" by one edge so the reader never sees a line before its last RAM write lands.
   always_comb begin
      w_rel = i_release & r_line_valid;
      w_pend_nxt = '0;
      w_pend_nxt[i_mark_bank] = i_mark;
      w_full_nxt = r_full | r_pend;
      if (w_rel) w_full_nxt[r_rb] = 1'b0;
      w_rb_nxt = r_rb ^ bank_t'(w_rel);
   end
   assign o_empty      = ~(r_pend | r_full);
   assign o_empty_nxt  = ~(w_pend_nxt | w_full_nxt);
   assign o_line_valid = r_line_valid;
   assign o_line_bank  = r_rb;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_pend       <= '0;
         r_full       <= '0;
         r_rb         <= '0;
         r_line_valid <= 1'b0;
      end else begin
         r_pend       <= w_pend_nxt;
         r_full       <= w_full_nxt;
         r_rb         <= w_rb_nxt;
         r_line_valid <= w_full_nxt[w_rb_nxt];
      end
endmodule

// File: rtl/nabp_line_loader.sv
// nabp_line_loader: writes a sample stream into two ping-pong RAM banks and hands full lines to the reader.
// Ports: clk, reset_n (async, active-low); bus (nabp_line_loader_if.slave) carries stream, write port, line status.
// Optional feature macro: NABP_LINE_LOADER_ZERO_PAD_EN zero-pads a line cut short by in_last.
module nabp_line_loader
   import nabp_line_loader_pkg::*;
#(
   parameter int pDataLength = kFilteredDataLength,
   parameter int pLineSize   = kProjectionLineSize,
   parameter int pAddrLength = kSLength
)(
   input logic               clk,
   input logic               reset_n,
   nabp_line_loader_if.slave bus
);
   localparam logic [pAddrLength-1:0] LAST = pAddrLength'(pLineSize - 1);
   state_t                 r_state;
   logic [pAddrLength-1:0] r_cnt, r_addr;
   logic [pDataLength-1:0] r_data;
   logic                   r_we_0, r_we_1;
   bank_t                  r_fb;
   logic                   w_xfer, w_wr, w_done, w_pad;
   logic [1:0]             w_empty, w_empty_nxt;
`ifdef NABP_LINE_LOADER_ZERO_PAD_EN
   assign w_pad = r_state == ST_PAD;
`else
   logic w_unused_last;
   assign w_unused_last = bus.in_last;
   assign w_pad = 1'b0;
`endif
   assign w_xfer       = bus.in_valid & bus.in_ready;
   assign w_wr         = w_xfer | w_pad;
   assign w_done       = w_wr & (r_cnt == LAST);
   assign bus.in_ready = reset_n & (r_state == ST_FILL) & w_empty[r_fb];
   assign bus.wr_we_0  = r_we_0;
   assign bus.wr_we_1  = r_we_1;
   assign bus.wr_addr  = r_addr;
   assign bus.wr_data  = r_data;
   nabp_bank_tracker u_trk (
      .clk(clk), .reset_n(reset_n),
      .i_mark(w_done), .i_mark_bank(r_fb), .i_release(bus.line_release),
      .o_empty(w_empty), .o_empty_nxt(w_empty_nxt),
      .o_line_valid(bus.line_valid), .o_line_bank(bus.line_bank)
   );
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_state <= ST_FILL;
         r_cnt   <= '0;
         r_fb    <= '0;
         r_we_0  <= 1'b0;
         r_we_1  <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else begin
         r_we_0 <= w_wr & (r_fb == 1'b0);
         r_we_1 <= w_wr & (r_fb == 1'b1);
         if (w_wr) begin
            r_addr <= r_cnt;
            r_data <= w_pad ? '0 : bus.in_data;
            r_cnt  <= w_done ? '0 : r_cnt + 1'b1;
            r_fb   <= r_fb ^ bank_t'(w_done);
         end
         // Next-cycle emptiness lets a same-edge release of the other bank keep the loader in FILL.
         if (w_done)
            r_state <= w_empty_nxt[~r_fb] ? ST_FILL : ST_WAIT;
`ifdef NABP_LINE_LOADER_ZERO_PAD_EN
         else if (w_xfer & bus.in_last)
            r_state <= ST_PAD;
`endif
         else if (r_state == ST_WAIT && w_empty_nxt[r_fb])
            r_state <= ST_FILL;
      end
endmodule

// File: tb/tb_nabp_line_loader.sv
// tb_nabp_line_loader: directed and random stimulus checked against a line-level behavioural model.
module tb_nabp_line_loader;
   localparam int DW = 16, N = 8, AW = 3;
   logic clk = 1'b0, reset_n = 1'b0;
   always #5 clk = ~clk;
   nabp_line_loader_if #(.pDataLength(DW), .pAddrLength(AW)) bus ();
   nabp_line_loader #(.pDataLength(DW), .pLineSize(N), .pAddrLength(AW)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );
   int n_chk = 0, n_pass = 0;
   int m_cnt, m_done, m_rel, m_pad, cyc = 0;
   int vis_q[$];
   bit e_we0, e_we1, m_acc;
   int e_addr, e_data;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Occupied banks = completed, unreleased lines; a line becomes visible two cycles after its last transfer.
   function automatic int m_ready();
      return (vis_q.size() < 2 && m_pad == 0) ? 1 : 0;
   endfunction
   function automatic int m_valid();
      return (vis_q.size() > 0 && vis_q[0] <= cyc) ? 1 : 0;
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_done = 0; m_rel = 0; m_pad = 0; vis_q.delete();
      e_we0 = 0; e_we1 = 0; e_addr = 0; e_data = 0;
   endtask

   task automatic compare();
      chk("in_ready", int'(bus.in_ready), m_ready());
      chk("wr_we_0", int'(bus.wr_we_0), int'(e_we0));
      chk("wr_we_1", int'(bus.wr_we_1), int'(e_we1));
      chk("wr_addr", int'(bus.wr_addr), e_addr);
      chk("wr_data", int'(bus.wr_data), e_data);
      chk("line_valid", int'(bus.line_valid), m_valid());
      chk("line_bank", int'(bus.line_bank), m_rel % 2);
   endtask

   task automatic step(input bit v, input int d, input bit l, input bit r);
      bit xfer, rel, wr;
      @(negedge clk);
      compare();
      bus.in_valid = v; bus.in_data = DW'(d); bus.in_last = l; bus.line_release = r;
      xfer = v && m_ready() == 1;
      rel  = r && m_valid() == 1;
      wr   = xfer || m_pad > 0;
      e_we0 = wr && m_done % 2 == 0;
      e_we1 = wr && m_done % 2 == 1;
      if (wr) begin e_addr = m_cnt; e_data = xfer ? (d & 16'hffff) : 0; end
      if (rel) begin void'(vis_q.pop_front()); m_rel++; end
      if (m_pad > 0) m_pad--;
      if (wr) begin
         m_cnt++;
         if (m_cnt == N) begin m_cnt = 0; m_done++; vis_q.push_back(cyc + 2); end
`ifdef NABP_LINE_LOADER_ZERO_PAD_EN
         else if (xfer && l) m_pad = N - m_cnt;
`endif
      end
      m_acc = xfer;
      cyc++;
   endtask

   task automatic send(input int d, input bit l);
      int k = 0;
      do begin step(1'b1, d, l, 1'b0); k++; end while (!m_acc && k < 40);
      if (!m_acc) begin n_chk++; $display("FAIL send_timeout: data %0d not accepted, required within 40 cycles", d); end
   endtask

   task automatic idle(input bit r);
      step(1'b0, 0, 1'b0, r);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0; bus.line_release = 0;
      #1;
      chk("rst_in_ready", int'(bus.in_ready), 0);
      chk("rst_we0", int'(bus.wr_we_0), 0);
      chk("rst_we1", int'(bus.wr_we_1), 0);
      chk("rst_addr", int'(bus.wr_addr), 0);
      chk("rst_data", int'(bus.wr_data), 0);
      chk("rst_line_valid", int'(bus.line_valid), 0);
      chk("rst_line_bank", int'(bus.line_bank), 0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required within 2 ms");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0; bus.line_release = 0;
      do_reset();
      // one full line into bank 0
      for (int i = 1; i <= 8; i++) send(i, 0);
      idle(0);
      chk("t1_we0", int'(bus.wr_we_0), 1);
      chk("t1_addr7", int'(bus.wr_addr), 7);
      chk("t1_data8", int'(bus.wr_data), 8);
      chk("t1_valid_early", int'(bus.line_valid), 0);
      idle(0);
      chk("t1_valid", int'(bus.line_valid), 1);
      chk("t1_bank", int'(bus.line_bank), 0);
      chk("t1_ready", int'(bus.in_ready), 1);
      // second line fills bank 1, then backpressure holds sample 17
      for (int i = 9; i <= 16; i++) send(i, 0);
      repeat (3) step(1, 17, 0, 0);
      chk("t2_stall_ready", int'(bus.in_ready), 0);
      chk("t2_stall_we1", int'(bus.wr_we_1), 0);
      step(1, 17, 0, 1);
      step(1, 17, 0, 0);
      chk("t2_bank1", int'(bus.line_bank), 1);
      chk("t2_ready", int'(bus.in_ready), 1);
      idle(0);
      chk("t2_we0", int'(bus.wr_we_0), 1);
      chk("t2_addr0", int'(bus.wr_addr), 0);
      chk("t2_data17", int'(bus.wr_data), 17);
      for (int i = 18; i <= 20; i++) send(i, 0);
      // release bank 1, then a release with nothing valid is ignored
      idle(1);
      idle(1);
      chk("t3_bank", int'(bus.line_bank), 0);
      chk("t3_valid", int'(bus.line_valid), 0);
      idle(0);
      chk("t3_bank_hold", int'(bus.line_bank), 0);
      chk("t3_ready", int'(bus.in_ready), 1);
      send(21, 0);
      idle(0);
      chk("t3_addr4", int'(bus.wr_addr), 4);
      chk("t3_data21", int'(bus.wr_data), 21);
      for (int i = 22; i <= 24; i++) send(i, 0);
      // final transfer into bank 1 together with release of bank 0
      for (int i = 25; i <= 31; i++) send(i, 0);
      idle(0); idle(0);
      step(1, 32, 0, 1);
      idle(0);
      chk("t4_bank1", int'(bus.line_bank), 1);
      chk("t4_valid_low", int'(bus.line_valid), 0);
      chk("t4_ready", int'(bus.in_ready), 1);
      idle(0);
      chk("t4_valid", int'(bus.line_valid), 1);
      // reset mid-line
      for (int i = 33; i <= 35; i++) send(i, 0);
      do_reset();
      send(16'h55, 0);
      idle(0);
      chk("t5_we0", int'(bus.wr_we_0), 1);
      chk("t5_addr0", int'(bus.wr_addr), 0);
      chk("t5_data55", int'(bus.wr_data), 16'h55);
      for (int i = 1; i <= 7; i++) send(16'h55 + i, 0);
      idle(0);
      chk("t5_valid_low", int'(bus.line_valid), 0);
      idle(0);
      chk("t5_valid", int'(bus.line_valid), 1);
      chk("t5_bank", int'(bus.line_bank), 0);
`ifdef NABP_LINE_LOADER_ZERO_PAD_EN
      do_reset();
      send(1, 0); send(2, 0); send(3, 1);
      idle(0);
      chk("pad_ready0", int'(bus.in_ready), 0);
      for (int i = 0; i < 5; i++) begin
         idle(0);
         chk("pad_we0", int'(bus.wr_we_0), 1);
         chk("pad_addr", int'(bus.wr_addr), 3 + i);
         chk("pad_data", int'(bus.wr_data), 0);
      end
      idle(0);
      chk("pad_valid", int'(bus.line_valid), 1);
      chk("pad_bank", int'(bus.line_bank), 0);
`endif
      // random traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         step($urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)),
              $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
      end
      idle(0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
